// File: rtl/image_streamer.sv
// Buffers one image via a random-access write port and streams it out word by word.
// Latency: first word one cycle after start; backpressure: output held stable while m_ready is low.
module image_streamer #(
  parameter int IMAGE_SIZE = 784,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_err,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0]        m_index,
  output logic                     m_last,
  output logic                     done,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_STREAM = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_SIZE - 1);
  localparam logic [ADDR_W:0]   SIZE_X   = (ADDR_W + 1)'(IMAGE_SIZE);

  logic [0:0]               state;
  logic [ADDR_W-1:0]        idx;
  logic signed [DATA_W-1:0] mem [IMAGE_SIZE];

  logic in_idle;
  logic in_stream;
  logic addr_ok;
  logic wr_ok;
  logic at_last;
  logic xfer;
  logic xfer_last;

  assign in_idle   = (state == S_IDLE);
  assign in_stream = (state == S_STREAM);
  assign addr_ok   = ({1'b0, wr_addr} < SIZE_X);
  assign wr_ok     = wr_en & in_idle & addr_ok;
  assign at_last   = (idx == LAST_IDX);
  // abort wins over a simultaneous handshake, so it also suppresses completion
  assign xfer      = in_stream & m_ready & ~abort;
  assign xfer_last = xfer & at_last;

  // The buffer survives reset; only the write path touches it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en & ~(in_idle & addr_ok);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_STREAM;
            idx   <= '0;
          end
        end
        S_STREAM: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
          end else if (xfer_last) begin
            state     <= S_IDLE;
            idx       <= '0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end else if (xfer) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Buffer is write-locked during STREAM, so a direct read of mem[idx] stays stable under stall.
  assign busy    = in_stream;
  assign m_valid = in_stream;
  assign m_index = idx;
  assign m_last  = in_stream & at_last;
  assign m_data  = in_stream ? mem[idx] : '0;

endmodule

// File: tb/tb_image_streamer.sv
// Scoreboarded bench for image_streamer: a reference image array feeds an expected-word queue,
// and a negedge monitor pops and compares each handshake.
module tb_image_streamer;

  localparam int N  = 784;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 2;
  localparam int CMASK = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 wr_en, start, abort, m_ready;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 wr_err, busy, m_valid, m_last, done;
  logic signed [DW-1:0] m_data;
  logic [AW-1:0]        m_index;
  logic [CW-1:0]        frame_cnt;

  image_streamer #(.IMAGE_SIZE(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .abort(abort), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] d;
    int                   i;
    bit                   l;
  } word_t;

  int                   total = 0;
  int                   bad = 0;
  logic signed [DW-1:0] img [N];
  word_t                exp_q[$];
  int                   fc_model = 0;
  bit                   exp_done = 0;
  int                   rdy_mode = 0;
  int                   rphase = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
        rphase++;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: anything seen at a negedge with valid&ready&!abort transfers at the next rising edge.
  bit    have_hold = 0;
  word_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {m_valid, busy, done, wr_err, m_last}, 0);
      chk("reset_data", m_data, 0);
      chk("reset_index", m_index, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      fc_model  = 0;
      exp_done  = 0;
      have_hold = 0;
    end else begin
      chk("done", done, exp_done);
      chk("frame_cnt", frame_cnt, fc_model & CMASK);
      if (have_hold && m_valid) begin
        chk("hold_data", m_data, held.d);
        chk("hold_index", m_index, held.i);
        chk("hold_last", m_last, held.l);
      end
      exp_done  = 0;
      have_hold = 0;
      if (m_valid && m_ready && !abort) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual_index=%0d required=none", m_index);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("xfer_data", m_data, w.d);
          chk("xfer_index", m_index, w.i);
          chk("xfer_last", m_last, w.l);
          if (w.l) begin
            exp_done = 1;
            fc_model++;
          end
        end
      end else if (m_valid && !m_ready) begin
        have_hold = 1;
        held.d = m_data;
        held.i = int'(m_index);
        held.l = m_last;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic signed [DW-1:0] d, input bit streaming);
    bit err;
    err = streaming || (a >= N);
    wr_en = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    chk("wr_err", wr_err, err);
    if (!err) img[a] = d;
  endtask

  task automatic start_frame(input bit w, input int a, input logic signed [DW-1:0] d);
    if (w) begin
      wr_en = 1'b1;
      wr_addr = a[AW-1:0];
      wr_data = d;
      img[a] = d;
    end
    start = 1'b1;
    for (int i = 0; i < N; i++) begin
      word_t e;
      e.d = img[i];
      e.i = i;
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (w) chk("start_wr_err", wr_err, 0);
    chk("start_valid", m_valid, 1);
    chk("start_busy", busy, 1);
    chk("start_index", m_index, 0);
    chk("start_data", m_data, img[0]);
    chk("start_last", m_last, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 6000 && done !== 1'b1) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    chk("end_valid", m_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_index(input int ix);
    int n;
    n = 0;
    while (n < 3000 && !(m_valid === 1'b1 && m_index == ix[AW-1:0])) begin
      tick();
      n++;
    end
    if (!(m_valid === 1'b1 && m_index == ix[AW-1:0])) begin
      total++;
      bad++;
      $display("FAIL index_timeout actual=%0d required=%0d", m_index, ix);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wr_en = 0; start = 0; abort = 0; wr_addr = '0; wr_data = '0; m_ready = 0;
    for (int i = 0; i < N; i++) img[i] = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: ramp image, full-rate stream
    for (int i = 0; i < N; i++) wr(i, i - 392, 0);
    rdy_mode = 0;
    start_frame(0, 0, 0);
    wait_done(n);
    chk("full_rate_cycles", n + 1, 785);
    chk("frame_cnt_t1", frame_cnt, 1);
    tick();

    // 2: stalls with 1,0,0,1 ready pattern
    rdy_mode = 1;
    rphase = 0;
    start_frame(0, 0, 0);
    wait_done(n);
    rdy_mode = 0;
    tick();

    // 3: rejected writes (out of range, during stream)
    wr(784, 123, 0);
    start_frame(0, 0, 0);
    repeat (3) tick();
    wr(5, 99, 1);
    wait_done(n);
    tick();
    start_frame(0, 0, 0);
    wait_done(n);
    tick();

    // 4: abort on the cycle index 300 would transfer
    start_frame(0, 0, 0);
    wait_index(300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_index", m_index, 0);
    exp_q.delete();
    repeat (4) tick();
    chk("abort_frame_cnt", frame_cnt, fc_model & CMASK);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    start_frame(0, 0, 0);
    wait_done(n);
    tick();

    // 5: reset mid-stream at index 100
    start_frame(0, 0, 0);
    wait_index(100);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(0, 0, 0);
    wait_done(n);
    chk("frame_cnt_t5", frame_cnt, 1);

    // 6: back-to-back frames with start during done, then counter wrap
    do_reset();
    for (int f = 0; f < 5; f++) begin
      start_frame(0, 0, 0);
      wait_done(n);
      chk("b2b_cycles", n + 1, 785);
      if (f == 2) chk("frame_cnt_three", frame_cnt, 3);
    end
    chk("frame_cnt_wrap", frame_cnt, 5 % (1 << CW));
    tick();

    // 7: random image, random writes incl. out of range, random ready, write+start together
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) wr($urandom_range(N, 1023), $urandom, 0);
      else wr($urandom_range(0, N - 1), $urandom, 0);
    end
    rdy_mode = 2;
    start_frame(1, $urandom_range(0, N - 1), $urandom);
    wait_done(n);
    rdy_mode = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Producer side of the pixel interface into the first dense layer.
- Holds one full image (IMAGE_SIZE signed words), loaded through a random-access write port.
- On start, streams the image word by word over a valid/ready handshake with index and last markers.
- Replaces the all-at-once parallel image bus, so the layer MAC can run sequentially.

Parameters:
IMAGE_SIZE, 784, number of pixel words per image
DATA_W, 32, width of each signed pixel word
ADDR_W, 10, width of write address and stream index; must satisfy 2**ADDR_W >= IMAGE_SIZE
CNT_W, 16, width of the completed-frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  buffer write address
wr_data  input  DATA_W  signed pixel word to write
wr_err  output  1  one-cycle pulse: write rejected
start  input  1  request to stream the buffered image
abort  input  1  cancel an in-progress stream
busy  output  1  high while in STREAM
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word
m_data  output  DATA_W  signed pixel word
m_index  output  ADDR_W  index of m_data within the image
m_last  output  1  high with the word at index IMAGE_SIZE-1
done  output  1  one-cycle pulse: full image delivered
frame_cnt  output  CNT_W  number of completed frames

Behaviour:
- Reset (asynchronous, rst_n low) forces every output to 0 and the state to IDLE.
  - Buffer contents are not cleared; reset mid-stream drops m_valid immediately and produces no done.
- States:
  - IDLE -> STREAM when start=1.
  - STREAM -> IDLE on the last handshake, or on abort.
- Writes:
  - Accepted only in IDLE with wr_addr < IMAGE_SIZE; mem[wr_addr] is updated at the clock edge.
  - A write in STREAM, or with wr_addr >= IMAGE_SIZE, is dropped and wr_err pulses high in the following cycle.
  - If start and wr_en are both high in IDLE, the write commits first; the stream then sees the new word.
- Start and busy:
  - start is accepted in IDLE. In the next cycle: busy=1, m_valid=1, m_index=0, m_data=mem[0], m_last=(IMAGE_SIZE==1).
  - start while busy is ignored.
- Handshake:
  - A transfer occurs on a rising edge with m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable.
  - After a transfer of index i < IMAGE_SIZE-1, the next cycle presents index i+1 with no bubble: sustained throughput is 1 word/cycle when m_ready is held high.
  - m_ready has no effect when m_valid=0.
- Completion:
  - Transfer with m_last=1: in the next cycle m_valid=0, busy=0, done=1 for exactly one cycle, and frame_cnt increments.
  - frame_cnt wraps from 2**CNT_W-1 to 0.
  - A new start may be accepted in the same cycle done is high.
- Abort:
  - abort=1 in STREAM: in the next cycle m_valid=0, busy=0, index returns to 0.
  - No done pulse and no frame_cnt change.
  - abort has priority over a simultaneous transfer, including the last one.
  - abort in IDLE has no effect.
- Data is passed through unmodified; there is no sign change or saturation.
- m_index equals the word's position in the image.

Test Plan:
1. Reset, then write mem[i]=i-392 for i=0..783; start; hold m_ready=1 -> 784 consecutive transfers with data -392..391 and index 0..783; m_last only on index 783; done one cycle later; frame_cnt=1; total 785 cycles from start to done.
2. Same image, m_ready toggling 1,0,0,1 repeatedly -> m_data/m_index held during every stall; exactly 784 transfers in order; single done pulse.
3. wr_en with wr_addr=784, and wr_en during STREAM at addr 5 with data 99 -> two wr_err pulses; mem[5] unchanged on the next stream.
4. Abort asserted at the transfer of index 300 -> m_valid low next cycle; no done; frame_cnt unchanged; a subsequent start restarts at index 0.
5. Drive rst_n low mid-stream at index 100 -> outputs 0 immediately; frame_cnt=0; a new start streams the still-intact buffer from index 0.
6. Start asserted in the same cycle as done, for three back-to-back frames -> frame_cnt=3; no index skip or bubble besides the one done cycle; set CNT_W=2 and run 5 frames -> frame_cnt wraps to 1.
